// File: rtl/can_tx_mailbox_arbiter_if.sv
// ---------------------------------------------------------------------------
// can_tx_mailbox_arbiter_if
//
// This interface bundles every signal between the transmit mailbox arbiter
// and its neighbours. It carries:
//   - the software-side mailbox write, abort and status signals, and
//   - the TX_REQ/TX_ID/TX_DLC/TX_DATA/TX_BUSY/TX_COMPLETE handshake with the
//     CAN TX controller.
//
// Modports:
//   slave  : the arbiter. It receives loads, aborts and controller status,
//            and drives mailbox status and the request fields.
//   master : the surrounding logic, that is the software-side logic and the
//            CAN controller together.
// ---------------------------------------------------------------------------
interface can_tx_mailbox_arbiter_if #(
    parameter int NUM_MB = 4
);
    // Mailbox write / abort side
    logic [NUM_MB-1:0] mb_load;
    logic [10:0]       mb_id_in;
    logic [3:0]        mb_dlc_in;
    logic [7:0]        mb_data_in [8];
    logic [NUM_MB-1:0] mb_abort;

    // Mailbox status
    logic [NUM_MB-1:0] mb_pending;
    logic [NUM_MB-1:0] mb_done;
    logic              load_err;
    logic              arb_busy;

    // Controller handshake
    logic              TX_REQ;
    logic [10:0]       TX_ID;
    logic [3:0]        TX_DLC;
    logic [7:0]        TX_DATA [8];
    logic              TX_BUSY;
    logic              TX_COMPLETE;

    modport slave (
        input  mb_load, mb_id_in, mb_dlc_in, mb_data_in, mb_abort,
        input  TX_BUSY, TX_COMPLETE,
        output mb_pending, mb_done, load_err, arb_busy,
        output TX_REQ, TX_ID, TX_DLC, TX_DATA
    );

    modport master (
        output mb_load, mb_id_in, mb_dlc_in, mb_data_in, mb_abort,
        output TX_BUSY, TX_COMPLETE,
        input  mb_pending, mb_done, load_err, arb_busy,
        input  TX_REQ, TX_ID, TX_DLC, TX_DATA
    );
endinterface

// File: rtl/can_tx_mailbox_arbiter.sv
// ---------------------------------------------------------------------------
// can_tx_mailbox_arbiter
//
// Purpose:
//   A transmit scheduler with NUM_MB mailboxes, placed in front of a CAN TX
//   controller. Each mailbox holds one frame: an ID, a DLC and 8 data bytes.
//   The arbiter picks the pending frame with the lowest 11-bit ID. When two
//   pending frames share an ID, the lowest mailbox index wins. It then runs
//   the TX_REQ/TX_BUSY/TX_COMPLETE handshake and pulses mb_done for the
//   mailbox that just finished.
//
// Ports:
//   clk : system clock. All logic runs on the rising edge.
//   rst : synchronous, active-high reset. It clears the state, every output
//         and the mailbox contents.
//   bus : can_tx_mailbox_arbiter_if.slave. This carries the mailbox
//         load/abort and status signals and the controller handshake.
// ---------------------------------------------------------------------------
module can_tx_mailbox_arbiter #(
    parameter int NUM_MB = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    can_tx_mailbox_arbiter_if.slave  bus
);
    localparam int SEL_W = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_REQ       = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_RELEASE   = 2'd3;

    logic [1:0]       state;
    logic [SEL_W-1:0] sel;

    // Mailbox storage
    logic [10:0] mb_id   [NUM_MB];
    logic [3:0]  mb_dlc  [NUM_MB];
    logic [7:0]  mb_data [NUM_MB][8];

    // Arbitration result for the current cycle
    logic              any_pending;
    logic [SEL_W-1:0]  best_idx;
    logic [10:0]       best_id;
    logic [NUM_MB-1:0] protect;
    logic [3:0]        dlc_clamped;

    // The scan runs from index 0 upward and uses a strict '<' compare.
    // Because of this, an ID tie keeps the lower index.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        any_pending = 1'b0;
        best_idx    = '0;
        best_id     = '1;
        for (int i = 0; i < NUM_MB; i++) begin
            if (bus.mb_pending[i] && (!any_pending || mb_id[i] < best_id)) begin
                any_pending = 1'b1;
                best_idx    = SEL_W'(i);
                best_id     = mb_id[i];
            end
        end
    end

    // A mailbox is protected from load and abort when it is in flight.
    // It is also protected in the IDLE cycle in which it is being granted.
    // Without that second case, a load in the granting cycle would overwrite
    // storage whose old contents are already being latched into TX_*, and
    // the new frame would then be retired without ever being sent.
    always_comb begin
        protect = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (state != ST_IDLE)
                protect[i] = (sel == SEL_W'(i));
            else
                protect[i] = any_pending && (best_idx == SEL_W'(i));
        end
    end

    assign dlc_clamped = (bus.mb_dlc_in > 4'd8) ? 4'd8 : bus.mb_dlc_in;

    // NOTE: sequential state uses non-blocking assignments only. This way
    // every register samples its inputs as they were before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the mailbox storage is reset as well. This means a frame
            // loaded before reset can never leak onto the bus after it.
            state          <= ST_IDLE;
            sel            <= '0;
            bus.mb_pending <= '0;
            bus.mb_done    <= '0;
            bus.load_err   <= 1'b0;
            bus.arb_busy   <= 1'b0;
            bus.TX_REQ     <= 1'b0;
            bus.TX_ID      <= '0;
            bus.TX_DLC     <= '0;
            for (int k = 0; k < 8; k++) bus.TX_DATA[k] <= '0;
            for (int i = 0; i < NUM_MB; i++) begin
                mb_id[i]  <= '0;
                mb_dlc[i] <= '0;
                for (int k = 0; k < 8; k++) mb_data[i][k] <= '0;
            end
        end else begin
            bus.mb_done  <= '0;
            bus.load_err <= |(bus.mb_load & protect);

            // Mailbox writes and aborts. A load wins over an abort on the
            // same mailbox.
            for (int i = 0; i < NUM_MB; i++) begin
                if (!protect[i]) begin
                    if (bus.mb_load[i]) begin
                        mb_id[i]          <= bus.mb_id_in;
                        mb_dlc[i]         <= dlc_clamped;
                        for (int k = 0; k < 8; k++) mb_data[i][k] <= bus.mb_data_in[k];
                        bus.mb_pending[i] <= 1'b1;
                    end else if (bus.mb_abort[i]) begin
                        bus.mb_pending[i] <= 1'b0;
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (any_pending) begin
                        sel          <= best_idx;
                        bus.TX_ID    <= mb_id[best_idx];
                        bus.TX_DLC   <= mb_dlc[best_idx];
                        for (int k = 0; k < 8; k++) bus.TX_DATA[k] <= mb_data[best_idx][k];
                        bus.TX_REQ   <= 1'b1;
                        bus.arb_busy <= 1'b1;
                        state        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.TX_BUSY) begin
                        bus.TX_REQ <= 1'b0;
                        state      <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    // The in-flight mailbox is never touched by the loop
                    // above, so this is the only write to its pending bit.
                    if (bus.TX_COMPLETE) begin
                        bus.mb_pending[sel] <= 1'b0;
                        bus.mb_done[sel]    <= 1'b1;
                        state               <= ST_RELEASE;
                    end
                end
                default: begin // ST_RELEASE
                    if (!bus.TX_BUSY && !bus.TX_COMPLETE) begin
                        bus.arb_busy <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
